// File: rtl/audio_level_meter_if.sv
// Sample-in / level-out bundle between the PCM source and the level meter.
interface audio_level_meter_if;
  logic               i_enable;
  logic               i_valid;
  logic signed [15:0] i_data;
  logic               i_clr_clip;
  logic               o_valid;
  logic [3:0]         o_bar;
  logic [3:0]         o_hold;
  logic [14:0]        o_peak;
  logic               o_clip;

  modport master (
    output i_enable, i_valid, i_data, i_clr_clip,
    input  o_valid, o_bar, o_hold, o_peak, o_clip
  );

  modport slave (
    input  i_enable, i_valid, i_data, i_clr_clip,
    output o_valid, o_bar, o_hold, o_peak, o_clip
  );
endinterface

// File: rtl/audio_level_meter.sv
// Per-frame peak detector with log2 quantisation, decaying bar, peak-hold marker and sticky clip flag.
module audio_level_meter #(
  parameter int unsigned WINDOW      = 1024,
  parameter int unsigned DECAY_STEP  = 1,
  parameter int unsigned HOLD_FRAMES = 8,
  parameter int unsigned CLIP_THRESH = 32000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  audio_level_meter_if.slave bus
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned MAG_W  = 15;
  localparam int unsigned LVL_W  = 4;
  localparam int unsigned HCNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_QUANT, S_UPDATE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [MAG_W-1:0]    acc_q;
  logic [MAG_W-1:0]    snap_q;
  logic [LVL_W-1:0]    qidx_q, qidx_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                upd_c;

  logic                valid_q;
  logic [LVL_W-1:0]    bar_q;
  logic [LVL_W-1:0]    hold_q;
  logic [HCNT_W-1:0]   hcnt_q;
  logic [MAG_W-1:0]    peak_q;
  logic                clip_q;

  logic [MAG_W-1:0]    mag_c;
  logic [15:0]         neg_c;
  logic                accept_c;
  logic                last_c;
  logic [MAG_W-1:0]    acc_max_c;
  logic [LVL_W-1:0]    bar_dec_c;
  logic [LVL_W-1:0]    bar_new_c;

  // |x| in 15 bits; the most negative code saturates to full scale
  always_comb begin
    neg_c = 16'(~bus.i_data + 16'sd1);
    if (bus.i_data == 16'sh8000) begin
      mag_c = '1;
    end else if (bus.i_data[15]) begin
      mag_c = neg_c[MAG_W-1:0];
    end else begin
      mag_c = bus.i_data[MAG_W-1:0];
    end
  end

  assign accept_c  = bus.i_valid & bus.i_enable;
  assign last_c    = accept_c && (cnt_q == CNT_W'(WINDOW - 1));
  assign acc_max_c = (mag_c > acc_q) ? mag_c : acc_q;

  // Frame accumulator; runs independently of the FSM so no sample is lost while quantising
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      snap_q <= '0;
    end else if (!bus.i_enable) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept_c) begin
      if (last_c) begin
        snap_q <= acc_max_c;
        acc_q  <= '0;
        cnt_q  <= '0;
      end else begin
        acc_q <= acc_max_c;
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      qidx_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      qidx_q  <= qidx_d;
      level_q <= level_d;
    end
  end

  // Fixed-length MSB scan: always 15 quant cycles regardless of where the top bit sits
  always_comb begin
    state_d = state_q;
    qidx_d  = qidx_q;
    level_d = level_q;
    upd_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (last_c) begin
          state_d = S_QUANT;
          qidx_d  = 4'd14;
          level_d = '0;
        end
      end
      S_QUANT: begin
        if ((level_q == '0) && snap_q[qidx_q]) begin
          level_d = 4'(qidx_q + 4'd1);
        end
        if (qidx_q == '0) begin
          state_d = S_UPDATE;
        end else begin
          qidx_d = qidx_q - 4'd1;
        end
      end
      S_UPDATE: begin
        upd_c   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bar_dec_c = (32'(bar_q) > DECAY_STEP) ? 4'(bar_q - 4'(DECAY_STEP)) : '0;
  assign bar_new_c = (level_q > bar_dec_c) ? level_q : bar_dec_c;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      bar_q   <= '0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      peak_q  <= '0;
    end else begin
      valid_q <= upd_c;
      if (upd_c) begin
        bar_q  <= bar_new_c;
        peak_q <= snap_q;
        if (level_q >= hold_q) begin
          hold_q <= level_q;
          hcnt_q <= HCNT_W'(HOLD_FRAMES);
        end else if (hcnt_q != '0) begin
          hcnt_q <= hcnt_q - 8'd1;
        end else if (hold_q != '0) begin
          hold_q <= hold_q - 4'd1;
        end
      end
    end
  end

  // Set has priority over a simultaneous clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clip_q <= 1'b0;
    end else if (accept_c && (32'(mag_c) >= CLIP_THRESH)) begin
      clip_q <= 1'b1;
    end else if (bus.i_clr_clip) begin
      clip_q <= 1'b0;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_bar   = bar_q;
  assign bus.o_hold  = hold_q;
  assign bus.o_peak  = peak_q;
  assign bus.o_clip  = clip_q;

endmodule
